// File: rtl/mux_scan_ctrl.sv
// Scans a 4:1 mux through channels 0..3, samples its output after a settle time,
// and publishes a 4-bit snapshot. Define MUX_SCAN_CONT_EN for level-triggered continuous scanning.
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_start,
    input  logic       in_mux_f,
    output logic [1:0] out_s,
    output logic       out_busy,
    output logic       out_done,
    output logic [3:0] out_data
);

    localparam int DW = (DWELL < 1) ? 1 : DWELL;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DW - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       data_q, data_d;
    logic [3:0]       shadow_q, shadow_d;
    logic             go;

`ifdef MUX_SCAN_CONT_EN
    assign go = in_start;
`else
    logic start_q;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= in_start;
        end
    end

    assign go = in_start & ~start_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        data_d   = data_q;
        shadow_d = shadow_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    state_d = SETTLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                shadow_d[sel_q] = in_mux_f;
                if (sel_q == 2'd3) begin
                    // Snapshot is published together with the last sample, so out_data never tears.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    data_d  = shadow_d;
                end else begin
                    state_d = SETTLE;
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MUX_SCAN_CONT_EN
                if (go) begin
                    state_d = SETTLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= 4'd0;
            shadow_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
        end
    end

    assign out_s    = sel_q;
    assign out_busy = busy_q;
    assign out_done = done_q;
    assign out_data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: three instances with DWELL = 2, 1, 0, each
// fed by a behavioural 4:1 mux model driving in_mux_f = x[out_s].
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       startV [3];
    logic [3:0] xV     [3];
    logic       muxV   [3];
    logic [1:0] sV     [3];
    logic       busyV  [3];
    logic       doneV  [3];
    logic [3:0] dataV  [3];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign muxV[0] = xV[0][sV[0]];
    assign muxV[1] = xV[1][sV[1]];
    assign muxV[2] = xV[2][sV[2]];

    mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) u0 (
        .in_clk(clk), .in_rst(rst), .in_start(startV[0]), .in_mux_f(muxV[0]),
        .out_s(sV[0]), .out_busy(busyV[0]), .out_done(doneV[0]), .out_data(dataV[0]));

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u1 (
        .in_clk(clk), .in_rst(rst), .in_start(startV[1]), .in_mux_f(muxV[1]),
        .out_s(sV[1]), .out_busy(busyV[1]), .out_done(doneV[1]), .out_data(dataV[1]));

    mux_scan_ctrl #(.DWELL(0), .CNT_W(8)) u2 (
        .in_clk(clk), .in_rst(rst), .in_start(startV[2]), .in_mux_f(muxV[2]),
        .out_s(sV[2]), .out_busy(busyV[2]), .out_done(doneV[2]), .out_data(dataV[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start on instance k and follows a full scan; pc = cycles per channel.
    task automatic run_scan(input int k, input int pc, input logic [3:0] x,
                            input logic [3:0] prev, input string tag);
        xV[k] = x;
        startV[k] = 1'b1;
        step();
        startV[k] = 1'b0;
        for (int i = 0; i < 4 * pc; i++) begin
            checks++;
            if (busyV[k] !== 1'b1 || sV[k] !== 2'(i / pc) || doneV[k] !== 1'b0 || dataV[k] !== prev) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: busy=%b s=%0d done=%b data=%b, expected busy=1 s=%0d done=0 data=%b",
                         tag, i + 1, busyV[k], sV[k], doneV[k], dataV[k], i / pc, prev);
            end
            step();
        end
        checks++;
        if (doneV[k] !== 1'b1 || busyV[k] !== 1'b0 || dataV[k] !== x || sV[k] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL %s done cycle: done=%b busy=%b data=%b s=%0d, expected done=1 busy=0 data=%b s=3",
                     tag, doneV[k], busyV[k], dataV[k], sV[k], x);
        end
        step();
        checks++;
        if (doneV[k] !== 1'b0 || busyV[k] !== 1'b0 || dataV[k] !== x || sV[k] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL %s after done: done=%b busy=%b data=%b s=%0d, expected done=0 busy=0 data=%b s=3",
                     tag, doneV[k], busyV[k], dataV[k], sV[k], x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sV[k] !== 2'd0 || busyV[k] !== 1'b0 || doneV[k] !== 1'b0 || dataV[k] !== 4'd0) begin
                errors++;
                $display("[TB] FAIL reset inst%0d: s=%0d busy=%b done=%b data=%b, expected all 0",
                         k, sV[k], busyV[k], doneV[k], dataV[k]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_scan();
        run_scan(0, 3, 4'b1010, 4'b0000, "single_scan");
    endtask

    task automatic test_snapshot_hold();
        step();
        run_scan(0, 3, 4'b0110, 4'b1010, "snapshot_hold");
    endtask

`ifndef MUX_SCAN_CONT_EN
    task automatic test_held_start();
        int busyCnt;
        int doneCnt;
        busyCnt = 0;
        doneCnt = 0;
        xV[0] = 4'b1100;
        step();
        startV[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busyV[0] === 1'b1) busyCnt++;
            if (doneV[0] === 1'b1) doneCnt++;
        end
        checks++;
        if (busyCnt != 12 || doneCnt != 1) begin
            errors++;
            $display("[TB] FAIL held_start: busy cycles=%0d done pulses=%0d, expected 12 and 1", busyCnt, doneCnt);
        end
        checks++;
        if (busyV[0] !== 1'b0 || dataV[0] !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL held_start idle: busy=%b data=%b, expected busy=0 data=1100", busyV[0], dataV[0]);
        end
        startV[0] = 1'b0;
        step();
        checks++;
        if (busyV[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL held_start release: busy=%b, expected 0", busyV[0]);
        end
        run_scan(0, 3, 4'b0101, 4'b1100, "rearm_scan");
    endtask
`else
    task automatic test_continuous();
        logic [3:0] xs [2];
        int doneCnt;
        xs[0] = 4'b0011;
        xs[1] = 4'b1100;
        doneCnt = 0;
        xV[0] = xs[0];
        step();
        startV[0] = 1'b1;
        step();
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (busyV[0] !== 1'b1 || sV[0] !== 2'(i / 3) || doneV[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL continuous scan%0d cycle %0d: busy=%b s=%0d done=%b, expected busy=1 s=%0d done=0",
                             n, i + 1, busyV[0], sV[0], doneV[0], i / 3);
                end
                if (n == 1 && i == 4) startV[0] = 1'b0;
                step();
            end
            checks++;
            if (doneV[0] !== 1'b1 || busyV[0] !== 1'b0 || dataV[0] !== xs[n]) begin
                errors++;
                $display("[TB] FAIL continuous done%0d: done=%b busy=%b data=%b, expected done=1 busy=0 data=%b",
                         n, doneV[0], busyV[0], dataV[0], xs[n]);
            end
            xV[0] = xs[1];
            step();
        end
        for (int i = 0; i < 6; i++) begin
            if (busyV[0] !== 1'b0 || doneV[0] !== 1'b0) doneCnt++;
            step();
        end
        checks++;
        if (doneCnt != 0 || dataV[0] !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL continuous idle: active cycles=%0d data=%b, expected 0 and 1100", doneCnt, dataV[0]);
        end
    endtask
`endif

    task automatic test_reset_mid_scan();
        int waitCnt;
        int doneCnt;
        waitCnt = 0;
        doneCnt = 0;
        xV[0] = 4'b1111;
        step();
        startV[0] = 1'b1;
        step();
        startV[0] = 1'b0;
        while (sV[0] !== 2'd2 && waitCnt < 20) begin
            step();
            waitCnt++;
        end
        checks++;
        if (sV[0] !== 2'd2) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan wait: s=%0d, expected 2 within 20 cycles", sV[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busyV[0] !== 1'b0 || sV[0] !== 2'd0 || dataV[0] !== 4'd0 || doneV[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan: busy=%b s=%0d data=%b done=%b, expected all 0",
                     busyV[0], sV[0], dataV[0], doneV[0]);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            if (doneV[0] === 1'b1 || busyV[0] === 1'b1) doneCnt++;
        end
        checks++;
        if (doneCnt != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_scan aftermath: active cycles=%0d, expected 0", doneCnt);
        end
    endtask

    task automatic test_dwell_boundary();
        run_scan(1, 2, 4'b0001, 4'b0000, "dwell1");
        run_scan(2, 2, 4'b0001, 4'b0000, "dwell0");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            startV[k] = 1'b0;
            xV[k] = 4'b0000;
        end
        test_reset();
        test_single_scan();
        test_snapshot_hold();
`ifndef MUX_SCAN_CONT_EN
        test_held_start();
`else
        test_continuous();
`endif
        test_reset_mid_scan();
        test_dwell_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
